// File: rtl/bpu_resolve.sv
// ============================================================================
// Module   : bpu_resolve
// Brief    : Resolves executed branches against their fetch-time prediction,
//            issuing front-end redirects and BTB/BHT/LPHT/RAS corrections.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bpu_resolve #(
    parameter int BHT_ADDR_WIDTH = 5,
    parameter int HIST_WIDTH     = 5,
    parameter int RAS_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      res_valid_i,
    input  logic                      res_epoch_i,
    input  logic [31:0]               res_pc_i,
    input  logic                      res_is_branch_i,
    input  logic                      res_dir_type_i,
    input  logic [1:0]                res_target_type_i,
    input  logic                      res_taken_i,
    input  logic [31:0]               res_target_i,
    input  logic                      pred_taken_i,
    input  logic [31:0]               pred_target_i,
    input  logic [HIST_WIDTH-1:0]     pred_hist_i,
    input  logic [1:0]                pred_lpht_i,
    input  logic [RAS_ADDR_WIDTH-1:0] pred_ras_ptr_i,
    output logic                      redirect_o,
    output logic [31:0]               redirect_target_o,
    output logic                      epoch_o,
    output logic                      btb_we_o,
    output logic [31:0]               btb_pc_o,
    output logic [31:0]               btb_target_o,
    output logic                      btb_dir_type_o,
    output logic [1:0]                btb_target_type_o,
    output logic                      bht_we_o,
    output logic [BHT_ADDR_WIDTH-1:0] bht_addr_o,
    output logic [HIST_WIDTH-1:0]     bht_data_o,
    output logic                      lpht_we_o,
    output logic [HIST_WIDTH-1:0]     lpht_addr_o,
    output logic [1:0]                lpht_data_o,
    output logic                      ras_restore_o,
    output logic [RAS_ADDR_WIDTH-1:0] ras_ptr_o,
    output logic [31:0]               branch_cnt_o,
    output logic [31:0]               mispredict_cnt_o
);

    localparam logic [1:0] c_tt_npc  = 2'd0;
    localparam logic [1:0] c_tt_call = 2'd1;
    localparam logic [1:0] c_tt_ret  = 2'd2;
    localparam logic [RAS_ADDR_WIDTH-1:0] c_ras_one = {{(RAS_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic                      r_epoch;
    logic                      r_redirect;
    logic [31:0]               r_redirect_target;
    logic                      r_btb_we;
    logic [31:0]               r_btb_pc;
    logic [31:0]               r_btb_target;
    logic                      r_btb_dir_type;
    logic [1:0]                r_btb_target_type;
    logic                      r_bht_we;
    logic [BHT_ADDR_WIDTH-1:0] r_bht_addr;
    logic [HIST_WIDTH-1:0]     r_bht_data;
    logic                      r_lpht_we;
    logic [HIST_WIDTH-1:0]     r_lpht_addr;
    logic [1:0]                r_lpht_data;
    logic                      r_ras_restore;
    logic [RAS_ADDR_WIDTH-1:0] r_ras_ptr;
    logic [31:0]               r_branch_cnt;
    logic [31:0]               r_mispredict_cnt;
    logic                      r_fwd_valid;
    logic [HIST_WIDTH-1:0]     r_fwd_idx;
    logic [1:0]                r_fwd_val;

    logic                      w_taken;
    logic                      w_accept;
    logic                      w_mispredict;
    logic                      w_cond;
    logic [31:0]               w_redirect_target;
    logic [BHT_ADDR_WIDTH-1:0] w_bht_idx;
    logic [HIST_WIDTH-1:0]     w_lpht_idx;
    logic [1:0]                w_lpht_base;
    logic [1:0]                w_lpht_new;
    logic [RAS_ADDR_WIDTH-1:0] w_ras_ptr;

    assign w_taken      = res_taken_i & res_is_branch_i;
    assign w_accept     = res_valid_i & (res_epoch_i == r_epoch) & ~flush_i;
    assign w_mispredict = (pred_taken_i != w_taken) |
                          (pred_taken_i & w_taken & (pred_target_i != res_target_i));
    assign w_cond       = res_is_branch_i & res_dir_type_i;
    assign w_redirect_target = w_taken ? res_target_i : res_pc_i + 32'd4;

    assign w_bht_idx  = res_pc_i[BHT_ADDR_WIDTH+1:2] ^ res_pc_i[2*BHT_ADDR_WIDTH+1:BHT_ADDR_WIDTH+2];
    assign w_lpht_idx = pred_hist_i ^ res_pc_i[HIST_WIDTH+1:2];

    // Back-to-back updates of one entry carry a stale snapshot; the last write wins.
    assign w_lpht_base = (r_fwd_valid && r_fwd_idx == w_lpht_idx) ? r_fwd_val : pred_lpht_i;

    always_comb begin
        w_lpht_new = w_lpht_base;
        if (w_taken) begin
            if (w_lpht_base != 2'd3) w_lpht_new = w_lpht_base + 2'd1;
        end else begin
            if (w_lpht_base != 2'd0) w_lpht_new = w_lpht_base - 2'd1;
        end
    end

    always_comb begin
        w_ras_ptr = pred_ras_ptr_i;
        if (res_target_type_i == c_tt_call)     w_ras_ptr = pred_ras_ptr_i + c_ras_one;
        else if (res_target_type_i == c_tt_ret) w_ras_ptr = pred_ras_ptr_i - c_ras_one;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_epoch           <= 1'b0;
            r_redirect        <= 1'b0;
            r_redirect_target <= '0;
            r_btb_we          <= 1'b0;
            r_btb_pc          <= '0;
            r_btb_target      <= '0;
            r_btb_dir_type    <= 1'b0;
            r_btb_target_type <= '0;
            r_bht_we          <= 1'b0;
            r_bht_addr        <= '0;
            r_bht_data        <= '0;
            r_lpht_we         <= 1'b0;
            r_lpht_addr       <= '0;
            r_lpht_data       <= '0;
            r_ras_restore     <= 1'b0;
            r_ras_ptr         <= '0;
            r_branch_cnt      <= '0;
            r_mispredict_cnt  <= '0;
            r_fwd_valid       <= 1'b0;
            r_fwd_idx         <= '0;
            r_fwd_val         <= '0;
        end else begin
            r_epoch       <= r_epoch ^ ((w_accept & w_mispredict) | flush_i);
            r_redirect    <= w_accept & w_mispredict;
            r_btb_we      <= w_accept & (w_taken | w_mispredict);
            r_bht_we      <= w_accept & w_cond;
            r_lpht_we     <= w_accept & w_cond;
            r_ras_restore <= w_accept & w_mispredict;
            if (w_accept) begin
                r_redirect_target <= w_redirect_target;
                r_btb_pc          <= res_pc_i;
                // A non-branch entry only has to kill the alias, so it points at the fall-through.
                r_btb_target      <= res_is_branch_i ? res_target_i : w_redirect_target;
                r_btb_dir_type    <= res_is_branch_i & res_dir_type_i;
                r_btb_target_type <= res_is_branch_i ? res_target_type_i : c_tt_npc;
                r_bht_addr        <= w_bht_idx;
                r_bht_data        <= {pred_hist_i[HIST_WIDTH-2:0], w_taken};
                r_lpht_addr       <= w_lpht_idx;
                r_lpht_data       <= w_lpht_new;
                r_ras_ptr         <= w_ras_ptr;
                r_branch_cnt      <= r_branch_cnt + {31'd0, res_is_branch_i};
                r_mispredict_cnt  <= r_mispredict_cnt + {31'd0, w_mispredict};
            end
            if (w_accept & w_cond) begin
                r_fwd_valid <= 1'b1;
                r_fwd_idx   <= w_lpht_idx;
                r_fwd_val   <= w_lpht_new;
            end
        end
    end

    assign epoch_o           = r_epoch;
    assign redirect_o        = r_redirect;
    assign redirect_target_o = r_redirect_target;
    assign btb_we_o          = r_btb_we;
    assign btb_pc_o          = r_btb_pc;
    assign btb_target_o      = r_btb_target;
    assign btb_dir_type_o    = r_btb_dir_type;
    assign btb_target_type_o = r_btb_target_type;
    assign bht_we_o          = r_bht_we;
    assign bht_addr_o        = r_bht_addr;
    assign bht_data_o        = r_bht_data;
    assign lpht_we_o         = r_lpht_we;
    assign lpht_addr_o       = r_lpht_addr;
    assign lpht_data_o       = r_lpht_data;
    assign ras_restore_o     = r_ras_restore;
    assign ras_ptr_o         = r_ras_ptr;
    assign branch_cnt_o      = r_branch_cnt;
    assign mispredict_cnt_o  = r_mispredict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_bpu_resolve.sv
// ============================================================================
// Module   : tb_bpu_resolve
// Brief    : Vector-table and scoreboard bench for bpu_resolve.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bpu_resolve;

    typedef struct {
        logic        valid;
        logic        ep;
        logic [31:0] pc;
        logic        isb;
        logic        dir;
        logic [1:0]  tt;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic [4:0]  hist;
        logic [1:0]  lp;
        logic [2:0]  rp;
        logic        fl;
    } in_t;

    typedef struct {
        logic        redir;
        logic [31:0] rtgt;
        logic        btb_we;
        logic [1:0]  btb_tt;
        logic        bht_we;
        logic [4:0]  bht_addr;
        logic [4:0]  bht_data;
        logic        lpht_we;
        logic [4:0]  lpht_addr;
        logic [1:0]  lpht_data;
        logic        ras;
        logic [2:0]  rptr;
        logic        ep;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int c_nv = 13;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        res_valid_i;
    logic        res_epoch_i;
    logic [31:0] res_pc_i;
    logic        res_is_branch_i;
    logic        res_dir_type_i;
    logic [1:0]  res_target_type_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic [4:0]  pred_hist_i;
    logic [1:0]  pred_lpht_i;
    logic [2:0]  pred_ras_ptr_i;
    logic        redirect_o;
    logic [31:0] redirect_target_o;
    logic        epoch_o;
    logic        btb_we_o;
    logic [31:0] btb_pc_o;
    logic [31:0] btb_target_o;
    logic        btb_dir_type_o;
    logic [1:0]  btb_target_type_o;
    logic        bht_we_o;
    logic [4:0]  bht_addr_o;
    logic [4:0]  bht_data_o;
    logic        lpht_we_o;
    logic [4:0]  lpht_addr_o;
    logic [1:0]  lpht_data_o;
    logic        ras_restore_o;
    logic [2:0]  ras_ptr_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[c_nv];
    exp_t sb[$];
    in_t  idle;

    bpu_resolve #(
        .BHT_ADDR_WIDTH(5),
        .HIST_WIDTH(5),
        .RAS_ADDR_WIDTH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .res_valid_i(res_valid_i), .res_epoch_i(res_epoch_i), .res_pc_i(res_pc_i),
        .res_is_branch_i(res_is_branch_i), .res_dir_type_i(res_dir_type_i),
        .res_target_type_i(res_target_type_i), .res_taken_i(res_taken_i),
        .res_target_i(res_target_i), .pred_taken_i(pred_taken_i),
        .pred_target_i(pred_target_i), .pred_hist_i(pred_hist_i),
        .pred_lpht_i(pred_lpht_i), .pred_ras_ptr_i(pred_ras_ptr_i),
        .redirect_o(redirect_o), .redirect_target_o(redirect_target_o),
        .epoch_o(epoch_o), .btb_we_o(btb_we_o), .btb_pc_o(btb_pc_o),
        .btb_target_o(btb_target_o), .btb_dir_type_o(btb_dir_type_o),
        .btb_target_type_o(btb_target_type_o), .bht_we_o(bht_we_o),
        .bht_addr_o(bht_addr_o), .bht_data_o(bht_data_o), .lpht_we_o(lpht_we_o),
        .lpht_addr_o(lpht_addr_o), .lpht_data_o(lpht_data_o),
        .ras_restore_o(ras_restore_o), .ras_ptr_o(ras_ptr_o),
        .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        flush_i           = v.fl;
        res_valid_i       = v.valid;
        res_epoch_i       = v.ep;
        res_pc_i          = v.pc;
        res_is_branch_i   = v.isb;
        res_dir_type_i    = v.dir;
        res_target_type_i = v.tt;
        res_taken_i       = v.tk;
        res_target_i      = v.tgt;
        pred_taken_i      = v.ptk;
        pred_target_i     = v.ptgt;
        pred_hist_i       = v.hist;
        pred_lpht_i       = v.lp;
        pred_ras_ptr_i    = v.rp;
    endtask

    task automatic cmp(input exp_t e);
        chk("redirect", {31'd0, redirect_o}, {31'd0, e.redir});
        if (e.redir) chk("redirect_target", redirect_target_o, e.rtgt);
        chk("btb_we", {31'd0, btb_we_o}, {31'd0, e.btb_we});
        if (e.btb_we) chk("btb_target_type", {30'd0, btb_target_type_o}, {30'd0, e.btb_tt});
        chk("bht_we", {31'd0, bht_we_o}, {31'd0, e.bht_we});
        if (e.bht_we) begin
            chk("bht_addr", {27'd0, bht_addr_o}, {27'd0, e.bht_addr});
            chk("bht_data", {27'd0, bht_data_o}, {27'd0, e.bht_data});
        end
        chk("lpht_we", {31'd0, lpht_we_o}, {31'd0, e.lpht_we});
        if (e.lpht_we) begin
            chk("lpht_addr", {27'd0, lpht_addr_o}, {27'd0, e.lpht_addr});
            chk("lpht_data", {30'd0, lpht_data_o}, {30'd0, e.lpht_data});
        end
        chk("ras_restore", {31'd0, ras_restore_o}, {31'd0, e.ras});
        if (e.ras) chk("ras_ptr", {29'd0, ras_ptr_o}, {29'd0, e.rptr});
        chk("epoch", {31'd0, epoch_o}, {31'd0, e.ep});
        chk("branch_cnt", branch_cnt_o, e.bc);
        chk("mispredict_cnt", mispredict_cnt_o, e.mc);
    endtask

    initial begin
        idle = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 2'd0, 3'd0, 1'b0};

        // Conditional mispredict, then two forwarded updates to the same LPHT entry
        vecs[0].i  = '{1'b1, 1'b0, 32'h1C000010, 1'b1, 1'b1, 2'd3, 1'b1, 32'h1C000100, 1'b0, 32'h0, 5'b00011, 2'd1, 3'd2, 1'b0};
        vecs[0].e  = '{1'b1, 32'h1C000100, 1'b1, 2'd3, 1'b1, 5'b00100, 5'b00111, 1'b1, 5'b00111, 2'd2, 1'b1, 3'd2, 1'b1, 32'd1, 32'd1};
        vecs[1].i  = '{1'b1, 1'b1, 32'h1C000010, 1'b1, 1'b1, 2'd3, 1'b1, 32'h1C000100, 1'b1, 32'h1C000100, 5'b00011, 2'd1, 3'd2, 1'b0};
        vecs[1].e  = '{1'b0, 32'h0, 1'b1, 2'd3, 1'b1, 5'b00100, 5'b00111, 1'b1, 5'b00111, 2'd3, 1'b0, 3'd0, 1'b1, 32'd2, 32'd1};
        vecs[2].i  = vecs[1].i;
        vecs[2].e  = '{1'b0, 32'h0, 1'b1, 2'd3, 1'b1, 5'b00100, 5'b00111, 1'b1, 5'b00111, 2'd3, 1'b0, 3'd0, 1'b1, 32'd3, 32'd1};
        // Predicted taken, actually not taken: fall-through redirect
        vecs[3].i  = '{1'b1, 1'b1, 32'h1C000040, 1'b1, 1'b1, 2'd3, 1'b0, 32'h1C000200, 1'b1, 32'h1C000200, 5'b00000, 2'd2, 3'd5, 1'b0};
        vecs[3].e  = '{1'b1, 32'h1C000044, 1'b1, 2'd3, 1'b1, 5'b10000, 5'b00000, 1'b1, 5'b10000, 2'd1, 1'b1, 3'd5, 1'b0, 32'd4, 32'd2};
        // Stale epoch right after the redirect is dropped
        vecs[4].i  = vecs[3].i;
        vecs[4].e  = '{1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 32'd4, 32'd2};
        // RETURN wrong target with ptr 0, CALL mispredict with ptr 7
        vecs[5].i  = '{1'b1, 1'b0, 32'h1C000060, 1'b1, 1'b0, 2'd2, 1'b1, 32'h1C000300, 1'b1, 32'h1C000304, 5'd0, 2'd0, 3'd0, 1'b0};
        vecs[5].e  = '{1'b1, 32'h1C000300, 1'b1, 2'd2, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 3'd7, 1'b1, 32'd5, 32'd3};
        vecs[6].i  = '{1'b1, 1'b1, 32'h1C000070, 1'b1, 1'b0, 2'd1, 1'b1, 32'h1C000400, 1'b0, 32'h0, 5'd0, 2'd0, 3'd7, 1'b0};
        vecs[6].e  = '{1'b1, 32'h1C000400, 1'b1, 2'd1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 3'd0, 1'b0, 32'd6, 32'd4};
        // Non-branch predicted taken (res_taken set to show it is ignored)
        vecs[7].i  = '{1'b1, 1'b0, 32'h1C000020, 1'b0, 1'b0, 2'd0, 1'b1, 32'h1C000999, 1'b1, 32'h1C000080, 5'd0, 2'd0, 3'd3, 1'b0};
        vecs[7].e  = '{1'b1, 32'h1C000024, 1'b1, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b1, 3'd3, 1'b1, 32'd6, 32'd5};
        // Mispredict alongside flush: nothing captured, epoch toggles once
        vecs[8].i  = '{1'b1, 1'b1, 32'h1C000040, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 1'b1, 32'h1C000200, 5'd0, 2'd2, 3'd5, 1'b1};
        vecs[8].e  = '{1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 32'd6, 32'd5};
        vecs[9].i  = idle;
        vecs[9].e  = vecs[8].e;
        // Correct not-taken conditional with saturation at 0 and upper-PC BHT fold
        vecs[10].i = '{1'b1, 1'b0, 32'h1C000850, 1'b1, 1'b1, 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 5'b11111, 2'd0, 3'd0, 1'b0};
        vecs[10].e = '{1'b0, 32'h0, 1'b0, 2'd0, 1'b1, 5'b00100, 5'b11110, 1'b1, 5'b01011, 2'd0, 1'b0, 3'd0, 1'b0, 32'd7, 32'd5};
        // Correct taken unconditional still refreshes BTB
        vecs[11].i = '{1'b1, 1'b0, 32'h1C000090, 1'b1, 1'b0, 2'd3, 1'b1, 32'h1C000500, 1'b1, 32'h1C000500, 5'd0, 2'd0, 3'd0, 1'b0};
        vecs[11].e = '{1'b0, 32'h0, 1'b1, 2'd3, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 32'd8, 32'd5};
        vecs[12].i = idle;
        vecs[12].e = '{1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 2'd0, 1'b0, 3'd0, 1'b0, 32'd8, 32'd5};

        rst_n = 1'b0;
        drive(idle);
        #12;
        chk("reset redirect", {31'd0, redirect_o}, 32'd0);
        chk("reset epoch", {31'd0, epoch_o}, 32'd0);
        chk("reset btb_we", {31'd0, btb_we_o}, 32'd0);
        chk("reset lpht_we", {31'd0, lpht_we_o}, 32'd0);
        chk("reset branch_cnt", branch_cnt_o, 32'd0);
        chk("reset mispredict_cnt", mispredict_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < c_nv; k++) begin
            @(negedge clk);
            if (sb.size() > 0) cmp(sb.pop_front());
            drive(vecs[k].i);
            sb.push_back(vecs[k].e);
        end
        @(negedge clk);
        if (sb.size() > 0) cmp(sb.pop_front());
        chk("scoreboard drained", sb.size(), 32'd0);

        // Reset mid-stream discards the pending outputs and the LPHT forward entry
        drive(vecs[0].i);
        @(posedge clk);
        #2;
        chk("pre-reset redirect", {31'd0, redirect_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset redirect", {31'd0, redirect_o}, 32'd0);
        chk("async reset lpht_we", {31'd0, lpht_we_o}, 32'd0);
        chk("async reset epoch", {31'd0, epoch_o}, 32'd0);
        chk("async reset mispredict_cnt", mispredict_cnt_o, 32'd0);
        drive(idle);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive('{1'b1, 1'b0, 32'h1C000010, 1'b1, 1'b1, 2'd3, 1'b1, 32'h1C000100, 1'b1, 32'h1C000100, 5'b00011, 2'd0, 3'd0, 1'b0});
        @(negedge clk);
        drive(idle);
        chk("post-reset lpht_we", {31'd0, lpht_we_o}, 32'd1);
        chk("post-reset lpht_data", {30'd0, lpht_data_o}, 32'd1);
        chk("post-reset redirect", {31'd0, redirect_o}, 32'd0);
        chk("post-reset branch_cnt", branch_cnt_o, 32'd1);
        @(negedge clk);
        chk("single-cycle lpht_we", {31'd0, lpht_we_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bpu_resolve.md
# bpu_resolve

Back-end half of the branch-prediction protocol: consumes resolved branches from execute together with the prediction snapshot that `npc` attached at fetch. It decides mispredictions, issues the front-end redirect (`rst_jmp`/`rst_target` of `npc`), and produces the BTB/BHT/LPHT write and RAS-pointer restore that `npc` applies on its correction port. All outputs are registered, one cycle after acceptance.

## Interface
- `BHT_ADDR_WIDTH`, 5: BHT index width.
- `HIST_WIDTH`, 5: BHT history width; equals LPHT index width.
- `RAS_ADDR_WIDTH`, 3: RAS pointer width.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: external pipeline flush (exception/ertn).
- `res_valid_i` in 1: a resolved instruction is presented.
- `res_epoch_i` in 1: fetch epoch carried with the instruction.
- `res_pc_i` in 32: instruction PC.
- `res_is_branch_i` in 1: instruction is a control transfer.
- `res_dir_type_i` in 1: 1 = conditional, 0 = unconditional.
- `res_target_type_i` in 2: 0 NPC, 1 CALL, 2 RETURN, 3 IMM.
- `res_taken_i` in 1: actual direction.
- `res_target_i` in 32: actual target.
- `pred_taken_i` in 1 / `pred_target_i` in 32: fetch-time prediction.
- `pred_hist_i` in HIST_WIDTH / `pred_lpht_i` in 2 / `pred_ras_ptr_i` in RAS_ADDR_WIDTH: fetch-time snapshots.
- `redirect_o` out 1 / `redirect_target_o` out 32: one-cycle front-end redirect.
- `epoch_o` out 1: current epoch, stamped on new fetches.
- `btb_we_o` out 1, `btb_pc_o` out 32, `btb_target_o` out 32, `btb_dir_type_o` out 1, `btb_target_type_o` out 2.
- `bht_we_o` out 1, `bht_addr_o` out BHT_ADDR_WIDTH, `bht_data_o` out HIST_WIDTH.
- `lpht_we_o` out 1, `lpht_addr_o` out HIST_WIDTH, `lpht_data_o` out 2.
- `ras_restore_o` out 1 / `ras_ptr_o` out RAS_ADDR_WIDTH.
- `branch_cnt_o` out 32 / `mispredict_cnt_o` out 32: wrapping statistics.

## Operation
- Accept = `res_valid_i & (res_epoch_i == epoch_q) & !flush_i`. Non-accepted inputs produce no output and no counter change.
- Mispredict = `pred_taken_i != taken`, or both taken and `pred_target_i != res_target_i`; taken = `res_taken_i & res_is_branch_i`.
- Redirect target: taken ? `res_target_i` : `res_pc_i + 4` (32-bit wrap).
- Epoch toggles on accepted mispredict or on `flush_i`; both in one cycle toggle once.
- BHT index = `pc[B+1:2] ^ pc[2B+1:B+2]`; history update (conditional branches only) = `{pred_hist_i[H-2:0], taken}`.
- LPHT index = `pred_hist_i ^ pc[H+1:2]` (pre-update history). Base counter = forward register value if forward valid and index matches, else `pred_lpht_i`. New = base+1 saturating at 3 if taken, base-1 saturating at 0 otherwise. Forward register (valid, index, value) captures every LPHT write; cleared by reset only.
- LPHT and BHT written only for accepted conditional branches. BTB written for every accepted branch that is taken or mispredicted; a non-branch predicted taken writes BTB with dir_type 0, target_type NPC to kill the alias.
- RAS restore only on mispredict: ptr = snapshot +1 for CALL, -1 for RETURN, else snapshot, modulo 2^R.
- `branch_cnt_o` increments per accepted branch; `mispredict_cnt_o` per accepted mispredict.

## Timing
- Accept at edge N -> all write/redirect outputs valid for exactly cycle N+1, then deassert unless another accept.
- `epoch_o` changes at the same edge the redirect registers; a resolve in cycle N+1 carrying the old epoch is dropped.
- `flush_i` in cycle N: nothing captured; outputs of an accept at N-1 still appear in N.
- Reset: all outputs 0, epoch 0, forward invalid, counters 0; asserting `rst_n` mid-stream discards pending outputs immediately.

## Test plan
- Conditional at pc 0x1C000010, pred not-taken, hist 5'b00011, lpht 1, actual taken to 0x1C000100 -> next cycle redirect to 0x1C000100, lpht_data 2 at addr 5'b00111, bht_data 5'b00111, epoch 0->1, mispredict_cnt 1.
- Same branch resolved back-to-back with stale snapshot lpht 1, both taken -> second lpht_data 3 via forwarding, saturates at 3 on a third.
- After mispredict, resolve with epoch 0 next cycle -> no outputs, counters unchanged.
- RETURN mispredicted with snapshot ptr 0 -> ras_restore with ptr 7; CALL with ptr 7 -> ptr 0.
- Non-branch predicted taken at 0x1C000020 -> redirect to 0x1C000024, btb_we with target_type 0, no lpht/bht write.
- Mispredict and `flush_i` same cycle -> no outputs, epoch toggles exactly once.
